pipo_share_arbiter: RTL and testbench
=====================================

# pipo_share_arbiter

Round-robin arbiter that shares one WIDTH-bit parallel-in/parallel-out holding register between two requesters. Each requester presents a parallel word and a request. The block grants one requester at a time, loads that word into the shared register, acknowledges the load, then enforces a hold window before the next grant. It sits between the requesting datapaths and the shared register, and owns the register's load timing.

## Interface
- WIDTH, 4: data width of the shared register and both request words.
- HOLD_CYCLES, 2: cycles the loaded value is held after a load before a new grant is allowed. Legal range is 0..15.
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req0  input  1  requester 0 load request.
- d0  input  WIDTH  requester 0 parallel data.
- req1  input  1  requester 1 load request.
- d1  input  WIDTH  requester 1 parallel data.
- ack0  output  1  requester 0 load acknowledge.
- ack1  output  1  requester 1 load acknowledge.
- q  output  WIDTH  shared register parallel output.
- owner  output  1  index of the requester that last loaded q.
- q_valid  output  1  high once q has been loaded at least once since reset.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - q=0, owner=0, q_valid=0, ack0=ack1=0, busy=0.
  - FSM=IDLE, hold counter=0, last-grant pointer=1, so requester 0 wins the first tie.
- FSM states: IDLE, LOAD, HOLD.
- IDLE:
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester not equal to the last-grant pointer.
  - On a grant, latch the grant index, update the pointer, and go to LOAD.
  - With no req, stay in IDLE.
- LOAD (exactly 1 cycle):
  - ack of the granted requester is high; the other ack is low. ack is a Moore output: state==LOAD and matching grant index.
  - At the edge ending LOAD: q <= d of the granted requester, owner <= grant index, q_valid <= 1.
  - If HOLD_CYCLES==0, next state is IDLE. Otherwise go to HOLD with counter=HOLD_CYCLES-1.
- HOLD:
  - q is frozen.
  - Counter decrements each cycle. When it is 0, the next state is IDLE.
  - Requests arriving during HOLD are neither dropped nor acknowledged; they are evaluated in IDLE.
- Requester protocol:
  - Hold req and d stable until ack is sampled high at a rising edge.
  - Deassert req on the following cycle.
  - A req still high in IDLE after its ack counts as a new request.
- Outside LOAD, d0/d1 are ignored, and q never changes except through LOAD or reset.

## Timing
- Grant latency: req sampled high in IDLE at edge E0. LOAD and ack occupy the cycle E0..E1. New q is visible after E1.
- Request-to-q latency is 2 edges.
- Load period per grant is 2+HOLD_CYCLES cycles (IDLE decision, LOAD, HOLD). Back-to-back grants under continuous contention therefore start every 2+HOLD_CYCLES cycles.
- Under continuous contention, grants strictly alternate 0,1,0,1…
- ack is high for exactly one cycle per grant. ack0 and ack1 are never high together.
- busy is high in LOAD and HOLD and low in IDLE.
- Asynchronous reset mid-LOAD: ack drops immediately and q=0. The interrupted load is lost and the requester must re-request.
- Reset release is synchronised by the integrator. The first grant occurs no earlier than the first edge after release.

## Test plan
- Reset: assert rst_n=0 mid-simulation without a clock edge. Required: q=0, owner=0, q_valid=0, ack0=ack1=0, busy=0.
- Single request: req0=1, d0=4'hA in IDLE. Required: ack0=1 for one cycle, then q=4'hA, owner=0, q_valid=1. busy is high for 1+HOLD_CYCLES cycles.
- Simultaneous first requests: req0=req1=1, d0=4'h3, d1=4'hC, held until each ack. Required: requester 0 granted first (q=4'h3). Requester 1 granted 2+HOLD_CYCLES cycles later (q=4'hC, owner=1).
- Continuous contention over 8 grants with HOLD_CYCLES=2. Required:
  - owner alternates 0,1,0,1….
  - ack pulses are exactly 4 cycles apart.
  - ack0 and ack1 are never high together.
- HOLD_CYCLES=0 build with req1 held continuously and re-requested each time. Required: ack1 every 2 cycles, busy toggling 1/0.
- Reset during HOLD: after a load of 4'h5, pulse rst_n low in HOLD. Required: q=0 immediately and FSM in IDLE. A pending req1 is granted at the first edge after release, LOAD follows, and q=d1.

Source files
------------

// File: rtl/pipo_share_arbiter.sv
// pipo_share_arbiter
// Round-robin arbiter that lets two requesters share one WIDTH-bit
// parallel-in/parallel-out holding register. A grant is decided in IDLE,
// the chosen word is loaded at the end of a single LOAD cycle, and the
// loaded value is then held for HOLD_CYCLES cycles before the next grant.
// All outputs come straight from flops so they are glitch-free and drop
// immediately on asynchronous reset.

module pipo_share_arbiter #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] q,
  output logic             owner,
  output logic             q_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Hold counter is 4 bits wide, enough for the 0..15 legal range.
  localparam logic       HOLD_ZERO = (HOLD_CYCLES == 0);
  localparam logic [3:0] HOLD_INIT = HOLD_ZERO ? 4'd0 : 4'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q,  last_d;
  logic [3:0]       cnt_q,   cnt_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             owner_q, owner_d;
  logic             valid_q, valid_d;
  logic             ack0_q,  ack0_d;
  logic             ack1_q,  ack1_d;
  logic             busy_q,  busy_d;

  // Round-robin pick: a lone requester wins outright; on a tie the
  // requester that did not win last time gets the grant.
  function automatic logic pick_grant(input logic r0, input logic r1,
                                      input logic last);
    logic g;
    if (r0 && r1) begin
      g = ~last;
    end else if (r1) begin
      g = 1'b1;
    end else begin
      g = 1'b0;
    end
    return g;
  endfunction

  // Next-state, datapath load and Moore output decode.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    owner_d = owner_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_d = pick_grant(req0, req1, last_q);
          last_d  = pick_grant(req0, req1, last_q);
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // The word is captured at the edge that ends LOAD, while the
        // requester is still holding it stable under its ack.
        data_d  = grant_q ? d1 : d0;
        owner_d = grant_q;
        valid_d = 1'b1;
        if (HOLD_ZERO) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default: begin
        // Unreachable encoding: recover to a safe idle state.
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Outputs are computed from the next state so the flops present
    // exactly the Moore decode of the current state.
    ack0_d = (state_d == ST_LOAD) && (grant_d == 1'b0);
    ack1_d = (state_d == ST_LOAD) && (grant_d == 1'b1);
    busy_d = (state_d != ST_IDLE);
  end

  // State, shared register and output flops; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
      data_q  <= {WIDTH{1'b0}};
      owner_q <= 1'b0;
      valid_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign q       = data_q;
  assign owner   = owner_q;
  assign q_valid = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_pipo_share_arbiter.sv
// Testbench for pipo_share_arbiter: two instances (HOLD_CYCLES=2 and 0)
// checked every cycle against a time-based reference model.

module tb_pipo_share_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]      r0_s, r1_s;
  logic [1:0][3:0] d0_s, d1_s;
  wire  [1:0]      a0_w, a1_w, own_w, qv_w, bz_w;
  wire  [1:0][3:0] q_w;

  pipo_share_arbiter #(.WIDTH(4), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(r0_s[0]), .d0(d0_s[0]), .req1(r1_s[0]), .d1(d1_s[0]),
    .ack0(a0_w[0]), .ack1(a1_w[0]), .q(q_w[0]), .owner(own_w[0]),
    .q_valid(qv_w[0]), .busy(bz_w[0])
  );

  pipo_share_arbiter #(.WIDTH(4), .HOLD_CYCLES(0)) dut_h0 (
    .clk(clk), .rst_n(rst_n),
    .req0(r0_s[1]), .d0(d0_s[1]), .req1(r1_s[1]), .d1(d1_s[1]),
    .ack0(a0_w[1]), .ack1(a1_w[1]), .q(q_w[1]), .owner(own_w[1]),
    .q_valid(qv_w[1]), .busy(bz_w[1])
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: arbiter described by grant times, not states.
  // A grant at edge G puts ack up until G+1, loads q at G+1, and the
  // next decision may happen at edge G+2+HOLD.
  int         hc [2] = '{2, 0};
  int         ecnt;
  int         free_e [2];
  int         gr_e   [2];
  int         ld_e   [2];
  int         g_m    [2];
  int         last_m [2];
  logic [3:0] q_m    [2];
  logic       own_m  [2];
  logic       val_m  [2];
  logic       keep0  [2];
  logic       keep1  [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      free_e[k] = 0;  gr_e[k] = -1;  ld_e[k] = -1;
      g_m[k] = 0;     last_m[k] = 1;
      q_m[k] = 4'h0;  own_m[k] = 1'b0;  val_m[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (ecnt == ld_e[k]) begin
        q_m[k]   = (g_m[k] == 1) ? d1_s[k] : d0_s[k];
        own_m[k] = (g_m[k] == 1);
        val_m[k] = 1'b1;
      end
      if (ecnt >= free_e[k] && (r0_s[k] || r1_s[k])) begin
        if (r0_s[k] && r1_s[k]) g_m[k] = 1 - last_m[k];
        else                    g_m[k] = r1_s[k] ? 1 : 0;
        last_m[k] = g_m[k];
        gr_e[k]   = ecnt;
        ld_e[k]   = ecnt + 1;
        free_e[k] = ecnt + 2 + hc[k];
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("i%0d_q", k),      {4'h0, q_w[k]}, {4'h0, q_m[k]});
      check($sformatf("i%0d_owner", k),  {7'h0, own_w[k]}, {7'h0, own_m[k]});
      check($sformatf("i%0d_qvalid", k), {7'h0, qv_w[k]}, {7'h0, val_m[k]});
      check($sformatf("i%0d_ack0", k),   {7'h0, a0_w[k]},
            {7'h0, (gr_e[k] == ecnt) && (g_m[k] == 0)});
      check($sformatf("i%0d_ack1", k),   {7'h0, a1_w[k]},
            {7'h0, (gr_e[k] == ecnt) && (g_m[k] == 1)});
      check($sformatf("i%0d_busy", k),   {7'h0, bz_w[k]},
            {7'h0, ecnt < free_e[k] - 1});
      check($sformatf("i%0d_ack_excl", k), {7'h0, a0_w[k] & a1_w[k]}, 8'h00);
    end
  endtask

  // One clock: model at the edge, compare 1 time unit later, then apply
  // the requester protocol (drop or renew a request once it is loaded).
  task automatic step();
    @(posedge clk);
    ecnt++;
    model_edge();
    #1;
    check_all();
    for (int k = 0; k < 2; k++) begin
      if (ld_e[k] == ecnt && g_m[k] == 0) begin
        if (keep0[k]) d0_s[k] = 4'($urandom);
        else          r0_s[k] = 1'b0;
      end
      if (ld_e[k] == ecnt && g_m[k] == 1) begin
        if (keep1[k]) d1_s[k] = 4'($urandom);
        else          r1_s[k] = 1'b0;
      end
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    r0_s = 2'b00;  r1_s = 2'b00;
    d0_s = '0;     d1_s = '0;
    keep0 = '{1'b0, 1'b0};
    keep1 = '{1'b0, 1'b0};
    ecnt = 0;
    model_reset();
    #2;
    check_all();
    #1 rst_n = 1'b1;

    // Single request from requester 0.
    r0_s[0] = 1'b1;  d0_s[0] = 4'hA;
    for (int i = 0; i < 6; i++) step();
    check("single_q", {4'h0, q_w[0]}, 8'h0A);
    check("single_owner", {7'h0, own_w[0]}, 8'h00);

    // Simultaneous first requests after reset: 0 wins, then 1.
    do_reset();
    r0_s[0] = 1'b1;  d0_s[0] = 4'h3;
    r1_s[0] = 1'b1;  d1_s[0] = 4'hC;
    step(); step();
    check("tie_first_q", {4'h0, q_w[0]}, 8'h03);
    for (int i = 0; i < 4; i++) step();
    check("tie_second_q", {4'h0, q_w[0]}, 8'h0C);
    check("tie_second_owner", {7'h0, own_w[0]}, 8'h01);
    for (int i = 0; i < 4; i++) step();

    // Continuous contention for 8 grants; HOLD_CYCLES=0 instance with
    // requester 1 held and re-requesting every time.
    keep0[0] = 1'b1;  keep1[0] = 1'b1;
    r0_s[0]  = 1'b1;  r1_s[0]  = 1'b1;
    keep1[1] = 1'b1;  r1_s[1]  = 1'b1;  d1_s[1] = 4'h6;
    for (int i = 0; i < 32; i++) step();
    keep0 = '{1'b0, 1'b0};
    keep1 = '{1'b0, 1'b0};
    for (int i = 0; i < 8; i++) step();
    r0_s = 2'b00;  r1_s = 2'b00;
    for (int i = 0; i < 4; i++) step();

    // Reset during HOLD with a pending requester 1.
    r0_s[0] = 1'b1;  d0_s[0] = 4'h5;
    step();
    r1_s[0] = 1'b1;  d1_s[0] = 4'h9;
    step();
    check("hold_q_loaded", {4'h0, q_w[0]}, 8'h05);
    check("hold_busy", {7'h0, bz_w[0]}, 8'h01);
    do_reset();
    check("rst_q_cleared", {4'h0, q_w[0]}, 8'h00);
    step();
    check("rst_regrant_ack1", {7'h0, a1_w[0]}, 8'h01);
    step();
    check("rst_regrant_q", {4'h0, q_w[0]}, 8'h09);
    for (int i = 0; i < 4; i++) step();

    // Randomised traffic on both instances with occasional resets.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!r0_s[k] && $urandom_range(0, 2) == 0) begin
          r0_s[k] = 1'b1;  d0_s[k] = 4'($urandom);
          keep0[k] = ($urandom_range(0, 3) == 0);
        end
        if (!r1_s[k] && $urandom_range(0, 2) == 0) begin
          r1_s[k] = 1'b1;  d1_s[k] = 4'($urandom);
          keep1[k] = ($urandom_range(0, 3) == 0);
        end
      end
      if ($urandom_range(0, 99) == 0) do_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
